// File: rtl/led_flasher_pkg.sv
// led_flasher_pkg: shared types and widths for the LED flasher.
//   state_t  - per-channel sequence state (IDLE, ON, OFF)
//   PHASE_W  - width of the per-channel phase tick counter
//   FLASH_W  - width of the per-channel flash counter
//   PWM_W    - width of the shared brightness PWM counter
package led_flasher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam int PHASE_W = 8;
    localparam int FLASH_W = 4;
    localparam int PWM_W   = 4;

endpackage

// File: rtl/led_flasher_ch.sv
// led_flasher_ch: one LED channel sequencer.
//   clk, rst - clock and asynchronous active-high reset
//   tick     - shared prescaler tick
//   pwm_hi   - brightness gate applied to the lit state (constant 1 without PWM)
//   evt      - single-cycle trigger event
//   led      - registered LED drive
//   busy     - registered "sequence in progress" flag
// A sequence is FLASHES lit phases separated by dark phases, with no dark
// phase after the last flash. One extra trigger can be queued while busy.
module led_flasher_ch
    import led_flasher_pkg::*;
#(
    parameter int ON_TICKS  = 10,
    parameter int OFF_TICKS = 10,
    parameter int FLASHES   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic pwm_hi,
    input  logic evt,
    output logic led,
    output logic busy
);

    localparam logic [PHASE_W-1:0] ON_L  = PHASE_W'(ON_TICKS);
    localparam logic [PHASE_W-1:0] OFF_L = PHASE_W'(OFF_TICKS);
    localparam logic [FLASH_W-1:0] FL_L  = FLASH_W'(FLASHES);
    localparam logic [PHASE_W-1:0] PH_ONE = PHASE_W'(1);
    localparam logic [FLASH_W-1:0] FL_ONE = FLASH_W'(1);

    state_t               state, state_nxt;
    logic [PHASE_W-1:0]   phase, phase_nxt;
    logic [FLASH_W-1:0]   flash, flash_nxt;
    logic                 pend,  pend_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            phase <= '0;
            flash <= '0;
            pend  <= 1'b0;
            led   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            flash <= flash_nxt;
            pend  <= pend_nxt;
            // Outputs decode the next state so they line up with 'state'.
            led   <= (state_nxt == ON) && pwm_hi;
            busy  <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        flash_nxt = flash;
        pend_nxt  = pend;
        case (state)
            IDLE: begin
                if (evt) begin
                    state_nxt = ON;
                    phase_nxt = ON_L;
                    flash_nxt = FL_L;
                end
            end
            ON: begin
                if (evt) pend_nxt = 1'b1;
                if (tick) begin
                    phase_nxt = phase - 1'b1;
                    if (phase == PH_ONE) begin
                        flash_nxt = flash - 1'b1;
                        if (flash != FL_ONE) begin
                            state_nxt = OFF;
                            phase_nxt = OFF_L;
                        end else if (pend || evt) begin
                            // Queued (or coincident) trigger restarts straight into ON.
                            state_nxt = ON;
                            phase_nxt = ON_L;
                            flash_nxt = FL_L;
                            pend_nxt  = 1'b0;
                        end else begin
                            state_nxt = IDLE;
                            pend_nxt  = 1'b0;
                        end
                    end
                end
            end
            OFF: begin
                if (evt) pend_nxt = 1'b1;
                if (tick) begin
                    phase_nxt = phase - 1'b1;
                    if (phase == PH_ONE) begin
                        state_nxt = ON;
                        phase_nxt = ON_L;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                pend_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/led_tick_gen.sv
// led_tick_gen: free-running prescaler shared by all flasher channels.
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset (count returns to 0)
//   tick - one-cycle pulse while the count sits at TICK_DIV-1
module led_tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/led_flasher.sv
// led_flasher: W independent LED flash sequencers sharing one prescaler.
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   evt_in  - per-channel single-cycle trigger pulses
//   led_out - per-channel registered LED drive, active high
//   busy    - per-channel flag, high while a sequence runs
// Build option: define LEDFLASHER_PWM_EN to gate the lit state with a
// 4-bit free-running PWM counter (lit while counter < DUTY).
module led_flasher
    import led_flasher_pkg::*;
#(
    parameter int W         = 1,
    parameter int TICK_DIV  = 1000000,
    parameter int ON_TICKS  = 10,
    parameter int OFF_TICKS = 10,
    parameter int FLASHES   = 3,
    parameter int DUTY      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] evt_in,
    output logic [W-1:0] led_out,
    output logic [W-1:0] busy
);

    if (ON_TICKS < 1 || ON_TICKS > 255)   begin : g_bad_on    $error("ON_TICKS out of range");  end
    if (OFF_TICKS < 1 || OFF_TICKS > 255) begin : g_bad_off   $error("OFF_TICKS out of range"); end
    if (FLASHES < 1 || FLASHES > 15)      begin : g_bad_fl    $error("FLASHES out of range");   end
    if (DUTY < 0 || DUTY > 16)            begin : g_bad_duty  $error("DUTY out of range");      end

    logic tick;
    logic pwm_hi;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

`ifdef LEDFLASHER_PWM_EN
    localparam logic [PWM_W:0] DUTY_L = (PWM_W+1)'(DUTY);
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Extra MSB lets DUTY=16 compare as "always lit".
    assign pwm_hi = ({1'b0, pwm_cnt} < DUTY_L);
`else
    assign pwm_hi = 1'b1;
`endif

    for (genvar i = 0; i < W; i++) begin : g_ch
        led_flasher_ch #(
            .ON_TICKS  (ON_TICKS),
            .OFF_TICKS (OFF_TICKS),
            .FLASHES   (FLASHES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick),
            .pwm_hi (pwm_hi),
            .evt    (evt_in[i]),
            .led    (led_out[i]),
            .busy   (busy[i])
        );
    end

endmodule

// File: tb/tb_led_flasher.sv
// tb_led_flasher: randomized bench for led_flasher with a sequence-level
// reference model (each sequence is a fixed count of ticks; lit/dark is
// derived from elapsed ticks modulo the on+off period).
module tb_led_flasher;

    localparam int W     = 2;
    localparam int TD    = 4;
    localparam int ONT   = 2;
    localparam int OFFT  = 1;
    localparam int FL    = 2;
    localparam int DUTY  = 4;
    localparam int TOTAL = FL*ONT + (FL-1)*OFFT;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] evt_in = '0;
    logic [W-1:0] led_out;
    logic [W-1:0] busy;

    int checks   = 0;
    int failures = 0;

    led_flasher #(
        .W(W), .TICK_DIV(TD), .ON_TICKS(ONT), .OFF_TICKS(OFFT),
        .FLASHES(FL), .DUTY(DUTY)
    ) dut (
        .clk(clk), .rst(rst), .evt_in(evt_in), .led_out(led_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_pre;
    int m_pwm;
    bit m_pwm_ok;
    bit m_act  [W];
    int m_left [W];
    bit m_pend [W];

    task automatic model_reset();
        m_pre = 0;
        m_pwm = 0;
        m_pwm_ok = 1'b0;
        for (int c = 0; c < W; c++) begin
            m_act[c] = 1'b0; m_left[c] = 0; m_pend[c] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit tk;
        bit p;
        tk = (m_pre == TD-1);
        m_pre = (m_pre + 1) % TD;
        m_pwm_ok = (m_pwm < DUTY);
        m_pwm = (m_pwm + 1) % 16;
        for (int c = 0; c < W; c++) begin
            if (!m_act[c]) begin
                if (evt_in[c]) begin m_act[c] = 1'b1; m_left[c] = TOTAL; end
            end else begin
                p = m_pend[c] | evt_in[c];
                if (tk) m_left[c]--;
                if (m_left[c] == 0) begin
                    if (p) m_left[c] = TOTAL;
                    else   m_act[c]  = 1'b0;
                    m_pend[c] = 1'b0;
                end else begin
                    m_pend[c] = p;
                end
            end
        end
    endtask

    function automatic bit exp_led(int c);
        bit lit;
        lit = m_act[c] && (((TOTAL - m_left[c]) % (ONT + OFFT)) < ONT);
`ifdef LEDFLASHER_PWM_EN
        lit = lit && m_pwm_ok;
`endif
        return lit;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < W; c++) begin
                checks++;
                if (led_out[c] !== exp_led(c)) begin
                    failures++;
                    $display("FAIL led_out[%0d] t=%0t got=%b exp=%b", c, $time, led_out[c], exp_led(c));
                end
                checks++;
                if (busy[c] !== m_act[c]) begin
                    failures++;
                    $display("FAIL busy[%0d] t=%0t got=%b exp=%b", c, $time, busy[c], m_act[c]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input logic [W-1:0] e);
        evt_in = e;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check_lit(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_lit("async_rst_led", int'(led_out), 0);
        check_lit("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        evt_in = W'($urandom);
        @(negedge clk);
        evt_in = '0;
        rst = 1'b0;
    endtask

    initial begin
        int led_cnt, busy_cnt, b1_cnt;
        model_reset();
        repeat (3) @(negedge clk);
        evt_in = 2'b11;                 // ignored while in reset
        @(negedge clk);
        check_lit("reset_led", int'(led_out), 0);
        check_lit("reset_busy", int'(busy), 0);
        rst = 1'b0;

        // Single pulse right after release: ON 7, OFF 4, ON 8 cycles.
        led_cnt = 0; busy_cnt = 0; b1_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            cycle(i == 0 ? 2'b01 : 2'b00);
            if (led_out[0]) led_cnt++;
            if (busy[0])    busy_cnt++;
            if (busy[1])    b1_cnt++;
        end
        check_lit("single_busy_cycles", busy_cnt, 19);
`ifndef LEDFLASHER_PWM_EN
        check_lit("single_led_cycles", led_cnt, 15);
`endif
        check_lit("ch1_quiet", b1_cnt, 0);

        // Extra pulses during ON: second is queued, third dropped.
        cycle(2'b01); cycle(2'b00); cycle(2'b01); cycle(2'b01);
        repeat (50) cycle(2'b00);

        // Both channels, 3 cycles apart.
        cycle(2'b01); cycle(2'b00); cycle(2'b00); cycle(2'b10);
        repeat (30) cycle(2'b00);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            logic [W-1:0] e;
            for (int c = 0; c < W; c++) e[c] = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 499) == 0) async_reset();
            cycle(e);
        end
        repeat (40) cycle(2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
